// File: rtl/icache_assoc.sv
// Set-associative instruction cache with MRU-bit replacement and single-block refill.
// Optional ICACHE_PERF_EN adds saturating hit/miss counters.
module icache_way #(
  parameter int SETS   = 16,
  parameter int TAG_W  = 24,
  parameter int LINE_W = 128
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(SETS)-1:0]  widx,
  input  logic [TAG_W-1:0]         wtag,
  input  logic [LINE_W-1:0]        wline,
  input  logic [$clog2(SETS)-1:0]  ridx,
  input  logic [TAG_W-1:0]         rtag,
  output logic                     match,
  output logic [LINE_W-1:0]        rline
);
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [LINE_W-1:0] data_mem [SETS];

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[widx]  <= wtag;
      data_mem[widx] <= wline;
    end
  end

  assign match = (tag_mem[ridx] == rtag);
  assign rline = data_mem[ridx];
endmodule

module icache_assoc #(
  parameter int WAYS        = 4,
  parameter int SETS        = 16,
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_W      = 30
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cpu_req,
  input  logic [ADDR_W-1:0]                      cpu_addr,
  output logic                                   cpu_ready,
  output logic [31:0]                            cpu_rdata,
  input  logic                                   flush,
  output logic                                   mem_req,
  output logic [ADDR_W-$clog2(BLOCK_WORDS)-1:0]  mem_addr,
  input  logic                                   mem_ack,
  input  logic [32*BLOCK_WORDS-1:0]              mem_rdata
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]                            hit_cnt,
  output logic [31:0]                            miss_cnt
`endif
);
  localparam int OFF_W  = $clog2(BLOCK_WORDS);
  localparam int OW     = (OFF_W > 0) ? OFF_W : 1;
  localparam int IDX_W  = $clog2(SETS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int BLK_W  = ADDR_W - OFF_W;
  localparam int TAG_W  = BLK_W - IDX_W;
  localparam int LINE_W = 32 * BLOCK_WORDS;

  typedef enum logic [1:0] {IDLE, REFILL, FILL, FLUSH} state_e;

  state_e                       state_q, state_d;
  logic [BLK_W-1:0]             blk_q, blk_d;
  logic [WAY_W-1:0]             victim_q, victim_d;
  logic                         pend_q, pend_d;
  logic [LINE_W-1:0]            line_q, line_d;
  logic [SETS-1:0][WAYS-1:0]    valid_q, valid_d;
  logic [SETS-1:0][WAYS-1:0]    mru_q, mru_d;

  logic [BLK_W-1:0]             req_blk;
  logic [IDX_W-1:0]             req_idx, fill_idx;
  logic [TAG_W-1:0]             req_tag, fill_tag;
  logic [OW-1:0]                req_off;
  logic [WAYS-1:0]              way_we, way_match, hit_vec, valid_row, mru_row, cand;
  logic [WAYS-1:0][LINE_W-1:0]  way_line;
  logic [WAY_W-1:0]             hit_way, victim;
  logic [LINE_W-1:0]            line_sel;
  logic                         lookup_hit, miss_start;

  assign req_blk  = cpu_addr[ADDR_W-1:OFF_W];
  assign req_idx  = req_blk[IDX_W-1:0];
  assign req_tag  = req_blk[BLK_W-1:IDX_W];
  assign fill_idx = blk_q[IDX_W-1:0];
  assign fill_tag = blk_q[BLK_W-1:IDX_W];

  if (BLOCK_WORDS > 1) begin : g_off
    assign req_off = cpu_addr[OFF_W-1:0];
  end else begin : g_no_off
    assign req_off = '0;
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(.SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)) u_way (
      .clk   (clk),
      .we    (way_we[w]),
      .widx  (fill_idx),
      .wtag  (fill_tag),
      .wline (line_q),
      .ridx  (req_idx),
      .rtag  (req_tag),
      .match (way_match[w]),
      .rline (way_line[w])
    );
  end

  assign valid_row  = valid_q[req_idx];
  assign mru_row    = mru_q[req_idx];
  assign hit_vec    = way_match & valid_row;
  assign lookup_hit = |hit_vec;

  // Lowest-numbered candidate wins: invalid ways first, else ways with MRU bit clear.
  always_comb begin
    cand    = (&valid_row) ? ~mru_row : ~valid_row;
    victim  = '0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (cand[w])    victim  = WAY_W'(w);
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end

  function automatic logic [WAYS-1:0] mru_touch(input logic [WAYS-1:0] row,
                                                input logic [WAY_W-1:0] w);
    logic [WAYS-1:0] oh;
    oh    = '0;
    oh[w] = 1'b1;
    return (&(row | oh)) ? oh : (row | oh);
  endfunction

  assign line_sel  = way_line[hit_way];
  assign cpu_ready = (state_q == IDLE) && cpu_req && !flush && lookup_hit;
  assign cpu_rdata = cpu_ready ? line_sel[{req_off, 5'b0} +: 32] : 32'h0;
  assign mem_req   = (state_q == REFILL) && !mem_ack;
  assign mem_addr  = blk_q;

  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    victim_d   = victim_q;
    pend_d     = pend_q;
    line_d     = line_q;
    valid_d    = valid_q;
    mru_d      = mru_q;
    way_we     = '0;
    miss_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = FLUSH;
        end else if (cpu_req) begin
          if (lookup_hit) begin
            mru_d[req_idx] = mru_touch(mru_row, hit_way);
          end else begin
            state_d    = REFILL;
            blk_d      = req_blk;
            victim_d   = victim;
            miss_start = 1'b1;
          end
        end
      end
      REFILL: begin
        if (flush) pend_d = 1'b1;
        if (mem_ack) begin
          state_d = FILL;
          line_d  = mem_rdata;
        end
      end
      FILL: begin
        way_we[victim_q]            = 1'b1;
        valid_d[fill_idx][victim_q] = 1'b1;
        mru_d[fill_idx]             = mru_touch(mru_q[fill_idx], victim_q);
        pend_d                      = 1'b0;
        state_d                     = (pend_q || flush) ? FLUSH : IDLE;
      end
      FLUSH: begin
        valid_d = '0;
        mru_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      blk_q    <= '0;
      victim_q <= '0;
      pend_q   <= 1'b0;
      valid_q  <= '0;
      mru_q    <= '0;
    end else begin
      state_q  <= state_d;
      blk_q    <= blk_d;
      victim_q <= victim_d;
      pend_q   <= pend_d;
      valid_q  <= valid_d;
      mru_q    <= mru_d;
    end
  end

  // Refill staging register is datapath only; its content is meaningless until written.
  always_ff @(posedge clk) line_q <= line_d;

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (cpu_ready && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_d  = hit_cnt_q + 32'd1;
    if (miss_start && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: expected fetch words queued at request, popped on cpu_ready.
module tb_icache_assoc;
  logic         clk = 1'b0;
  logic         rst, cpu_req, flush, mem_ack;
  logic [29:0]  cpu_addr;
  logic         cpu_ready, mem_req;
  logic [31:0]  cpu_rdata;
  logic [27:0]  mem_addr;
  logic [127:0] mem_rdata;
`ifdef ICACHE_PERF_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  int tests = 0;
  int fails = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  icache_assoc dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_ready (cpu_ready),
    .cpu_rdata (cpu_rdata),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  // Memory image: word w of block b is {2'b10, b, w}, i.e. {2'b10, word address}.
  function automatic logic [31:0] word_of(input logic [29:0] a);
    return {2'b10, a};
  endfunction

  function automatic logic [127:0] block_of(input logic [27:0] b);
    logic [127:0] d;
    for (int w = 0; w < 4; w++) d[w*32 +: 32] = {2'b10, b, 2'(w)};
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_ready_data(input string tag);
    logic [31:0] exp;
    chk({tag, " ready"}, 32'(cpu_ready), 32'd1);
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s scoreboard empty observed=%h", tag, cpu_rdata);
    end else begin
      exp = sb.pop_front();
      chk({tag, " data"}, cpu_rdata, exp);
    end
  endtask

  task automatic hit(input logic [29:0] a, input string tag);
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = a;
    sb.push_back(word_of(a));
    #1 check_ready_data(tag);
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  task automatic miss(input logic [29:0] a, input int dly, input string tag);
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = a;
    sb.push_back(word_of(a));
    #1 chk({tag, " miss"}, 32'(cpu_ready), 32'd0);
    repeat (dly) begin
      @(negedge clk);
      #1 chk({tag, " mem_req"}, 32'(mem_req), 32'd1);
      chk({tag, " mem_addr"}, 32'(mem_addr), 32'(a[29:2]));
    end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = block_of(a[29:2]);
    #1 chk({tag, " mem_req drop on ack"}, 32'(mem_req), 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1 chk({tag, " no ready in fill"}, 32'(cpu_ready), 32'd0);
    @(negedge clk);
    #1 check_ready_data({tag, " retry"});
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  task automatic flush_idle(input logic [29:0] cached, input string tag);
    @(negedge clk);
    flush = 1'b1; cpu_req = 1'b1; cpu_addr = cached;
    #1 chk({tag, " flush beats hit"}, 32'(cpu_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1 chk({tag, " no ready in flush"}, 32'(cpu_ready), 32'd0);
    cpu_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    cpu_addr = '0; mem_rdata = '0;
    #2 rst = 1'b0;
    #1;
    chk("reset cpu_ready", 32'(cpu_ready), 32'd0);
    chk("reset cpu_rdata", cpu_rdata, 32'd0);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Basic miss: ack after 3 refill cycles, data two cycles later.
    miss(30'h40, 3, "addr40");
    hit(30'h41, "addr41 word1");
    hit(30'h43, "addr43 word3");

    // Fill set 0, touch way 0, fifth tag must evict way 1.
    flush_idle(30'h40, "flush1");
    miss(30'h040, 1, "s0 t1");
    miss(30'h080, 1, "s0 t2");
    miss(30'h0C0, 1, "s0 t3");
    miss(30'h100, 1, "s0 t4");
    hit(30'h040, "rehit way0");
    miss(30'h140, 2, "s0 t5");
    hit(30'h040, "way0 kept");
    hit(30'h0C0, "way2 kept");
    hit(30'h100, "way3 kept");
    hit(30'h142, "t5 present");
    miss(30'h080, 1, "way1 evicted");

    // MRU wrap: accesses to ways 0..3 in order leave only way 3 marked.
    flush_idle(30'h80, "flush2");
    miss(30'h040, 1, "wrap t1");
    miss(30'h080, 1, "wrap t2");
    miss(30'h0C0, 1, "wrap t3");
    miss(30'h100, 1, "wrap t4");
    miss(30'h140, 1, "wrap t5");
    hit(30'h080, "wrap way1 kept");
    hit(30'h0C0, "wrap way2 kept");
    hit(30'h100, "wrap way3 kept");
    miss(30'h040, 1, "wrap way0 evicted");

    // Flush arriving mid-refill: refill finishes, FLUSH runs, same address misses again.
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 30'h200;
    sb.push_back(word_of(30'h200));
    #1 chk("pf miss", 32'(cpu_ready), 32'd0);
    @(negedge clk);
    flush = 1'b1;
    #1 chk("pf mem_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    #1 chk("pf refill continues", 32'(mem_req), 32'd1);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = block_of(28'h80);
    #1 chk("pf mem_req drop", 32'(mem_req), 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1 chk("pf fill no ready", 32'(cpu_ready), 32'd0);
    @(negedge clk);
    #1 chk("pf flush no ready", 32'(cpu_ready), 32'd0);
    @(negedge clk);
    #1 chk("pf re-miss", 32'(cpu_ready), 32'd0);
    @(negedge clk);
    #1 chk("pf second refill", 32'(mem_req), 32'd1);
    chk("pf second addr", 32'(mem_addr), 32'h80);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = block_of(28'h80);
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    #1 check_ready_data("pf final");
    @(negedge clk);
    cpu_req = 1'b0;
    hit(30'h201, "pf cached");

    // Reset during refill: mem_req drops at once, stray ack ignored, line gone.
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 30'h300;
    #1 chk("rr miss", 32'(cpu_ready), 32'd0);
    @(negedge clk);
    #1 chk("rr mem_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rr mem_req async", 32'(mem_req), 32'd0);
    chk("rr mem_addr async", 32'(mem_addr), 32'd0);
    chk("rr cpu_ready", 32'(cpu_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = block_of(28'hC0);
    #1 chk("rr stray ack", 32'(mem_req), 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    miss(30'h200, 2, "rr post-reset");

`ifdef ICACHE_PERF_EN
    @(negedge clk);
    rst = 1'b0;
    #1 chk("perf reset hit", hit_cnt, 32'd0);
    chk("perf reset miss", miss_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    miss(30'h040, 1, "perf m1");
    miss(30'h080, 1, "perf m2");
    miss(30'h0C0, 1, "perf m3");
    hit(30'h041, "perf h1");
    hit(30'h081, "perf h2");
    @(negedge clk);
    #1 chk("perf miss_cnt", miss_cnt, 32'd3);
    chk("perf hit_cnt", hit_cnt, 32'd5);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/icache_assoc.md
ICACHE_ASSOC -- requirements
Module: icache_assoc

Interface
REQ-001 SHALL provide parameter WAYS, default 4, associativity, power of two, >=2.
REQ-002 SHALL provide parameter SETS, default 16, number of sets, power of two, >=2.
REQ-003 SHALL provide parameter BLOCK_WORDS, default 4, 32-bit words per block, power of two, >=1.
REQ-004 SHALL provide parameter ADDR_W, default 30, CPU word-address width.
REQ-005 SHALL provide port clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 SHALL provide port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL provide port cpu_req, input, 1, fetch request; held with cpu_addr until cpu_ready.
REQ-008 SHALL provide port cpu_addr, input, ADDR_W, word address split as [tag | index log2(SETS) | offset log2(BLOCK_WORDS)].
REQ-009 SHALL provide port cpu_ready, output, 1, fetch complete this cycle.
REQ-010 SHALL provide port cpu_rdata, output, 32, fetched word; valid only when cpu_ready=1, zero otherwise.
REQ-011 SHALL provide port flush, input, 1, one-cycle pulse requesting invalidation of all lines.
REQ-012 SHALL provide port mem_req, output, 1, block refill request.
REQ-013 SHALL provide port mem_addr, output, ADDR_W-log2(BLOCK_WORDS), block address [tag | index].
REQ-014 SHALL provide port mem_ack, input, 1, refill data valid; single-cycle pulse.
REQ-015 SHALL provide port mem_rdata, input, 32*BLOCK_WORDS, refill block; word 0 in bits [31:0].

Function
REQ-016 SHALL perform lookup combinationally in IDLE: hit = cpu_req and any way with valid=1 and tag match; on hit, cpu_ready=1 and cpu_rdata = addressed word in the same cycle.
REQ-017 SHALL implement FSM states IDLE, REFILL, FILL, FLUSH.
REQ-018 SHALL transition IDLE->REFILL on cpu_req miss and latch the block address; mem_req=1 and mem_addr stable throughout REFILL.
REQ-019 SHALL transition REFILL->FILL on mem_ack=1, capturing mem_rdata; mem_req deasserts in that same cycle (combinationally).
REQ-020 SHALL, in FILL, write data, tag and valid=1 into the victim way, then enter IDLE (or FLUSH if a flush is pending); the CPU retry hits in the next cycle, so miss latency = mem_ack cycle + 2.
REQ-021 SHALL select the victim as the lowest-numbered invalid way, else the lowest-numbered way with MRU bit 0; the victim is chosen at IDLE->REFILL and latched.
REQ-022 SHALL maintain per-set MRU bits: on hit or fill, set the accessed way's bit; if this would make all bits 1, clear all other bits of that set.
REQ-023 SHALL never assert cpu_ready outside IDLE; cpu_req dropping during REFILL does not abort the refill.
REQ-024 SHALL, on flush in IDLE, enter FLUSH next cycle, clear every valid and MRU bit in one cycle, assert no cpu_ready in FLUSH, then return to IDLE.
REQ-025 SHALL, on flush during REFILL or FILL, latch it as pending and complete the refill first; flush and mem_ack in the same cycle both take effect.
REQ-026 SHALL give flush priority over a simultaneous cpu_req in IDLE: no hit reported that cycle.

Reset
REQ-027 SHALL, on rst=0, asynchronously force IDLE, clear all valid and MRU bits, clear the pending flush, and drive cpu_ready=0, cpu_rdata=0, mem_req=0, mem_addr=0; data and tag arrays are not reset.
REQ-028 SHALL abandon any refill in progress on reset; a late mem_ack after reset release is ignored in IDLE.

Configuration
REQ-029 SHALL, when macro ICACHE_PERF_EN is defined, add outputs hit_cnt (32) and miss_cnt (32), counting IDLE hits and IDLE->REFILL transitions, saturating at 32'hFFFFFFFF, cleared by reset only.
REQ-030 SHALL, when ICACHE_PERF_EN is undefined, omit both ports and counters, with all other behaviour identical.

Verification
REQ-031 SHALL check: reset, cpu_req addr 0x40 -> miss, mem_req=1, mem_addr=0x10; mem_ack after 3 cycles -> cpu_ready 2 cycles later, data = word 0 of block.
REQ-032 SHALL check: WAYS=4, fill 4 tags into set 0, re-hit way 0, miss a 5th tag -> way 1 evicted; way 0 still hits.
REQ-033 SHALL check MRU wrap: hitting all 4 ways in order 0,1,2,3 -> MRU bits = 4'b1000; the next miss evicts way 0.
REQ-034 SHALL check: flush pulse during REFILL -> refill completes, FLUSH occurs, then the same address misses again.
REQ-035 SHALL check: rst low while mem_req=1 -> mem_req=0 immediately, a subsequent access misses, and a stray mem_ack is ignored.
REQ-036 SHALL check with ICACHE_PERF_EN: 3 misses + 5 hits -> miss_cnt=3, hit_cnt=5.
